// File: rtl/ita_act_packer_pkg.sv
// Shared constants and types for the activation output packer.
package ita_act_packer_pkg;

  localparam int N        = 16;
  localparam int WI       = 8;
  localparam int ACT_PACK = 4;
  localparam int BEAT_W   = N * WI;
  localparam int CNT_W    = (ACT_PACK > 2) ? $clog2(ACT_PACK) : 1;

  typedef logic [BEAT_W-1:0]          act_beat_t;
  typedef logic [ACT_PACK*N*WI-1:0]   act_word_t;
  typedef logic [ACT_PACK*N-1:0]      act_strb_t;
  typedef logic [CNT_W-1:0]           act_cnt_t;

endpackage

// File: rtl/ita_act_packer.sv
// Packs ACT_PACK consecutive N-lane activation beats into one wide output word.
// A tile end closes the word early; missing slots are zero with cleared strobes.
module ita_act_packer
  import ita_act_packer_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      valid_i,
  output logic      ready_o,
  input  act_beat_t data_i,
  input  logic      last_i,
  output logic      valid_o,
  input  logic      ready_i,
  output act_word_t data_o,
  output act_strb_t strb_o,
  output logic      last_o,
  output act_cnt_t  count_o
);

  localparam int       SLOTS   = ACT_PACK - 1;
  localparam act_cnt_t CNT_MAX = act_cnt_t'(ACT_PACK - 1);

  act_beat_t        slot_q [SLOTS];
  logic [SLOTS-1:0] slot_strb_q;
  act_cnt_t         cnt_q;
  logic             accept;
  logic             complete;
  act_word_t        word_d;
  act_strb_t        strb_d;

  assign ready_o  = !valid_o || ready_i;
  assign accept   = valid_i && ready_o;
  assign complete = accept && ((cnt_q == CNT_MAX) || last_i);
  assign count_o  = cnt_q;

  // Build the next output word: held slots below cnt, current beat at cnt, zeros above.
  always_comb begin
    word_d = '0;
    strb_d = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (act_cnt_t'(s) < cnt_q) begin
        if (slot_strb_q[s]) begin
          word_d[s*BEAT_W +: BEAT_W] = slot_q[s];
        end
        strb_d[s*N +: N] = {N{slot_strb_q[s]}};
      end else if (act_cnt_t'(s) == cnt_q) begin
        word_d[s*BEAT_W +: BEAT_W] = data_i;
        strb_d[s*N +: N]           = '1;
      end
    end
    if (cnt_q == CNT_MAX) begin
      word_d[SLOTS*BEAT_W +: BEAT_W] = data_i;
      strb_d[SLOTS*N +: N]           = '1;
    end
  end

  // Store non-completing beats in the assembly slot selected by the fill counter.
  always_ff @(posedge clk_i) begin
    if (accept && !complete) begin
      slot_q[cnt_q] <= data_i;
    end
  end

  // Fill counter, slot strobes and the registered output word with its handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      slot_strb_q <= '0;
      valid_o     <= 1'b0;
      data_o      <= '0;
      strb_o      <= '0;
      last_o      <= 1'b0;
    end else if (complete) begin
      data_o      <= word_d;
      strb_o      <= strb_d;
      last_o      <= last_i;
      valid_o     <= 1'b1;
      cnt_q       <= '0;
      slot_strb_q <= '0;
    end else begin
      if (accept) begin
        slot_strb_q[cnt_q] <= 1'b1;
        cnt_q              <= cnt_q + 1'b1;
      end
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
